// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU memory port arbiter.
package cpu_mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DISCARD} arb_state_t;
   localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data stages.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic                if_ready,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_be,
   output logic                mem_ready,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                m_valid,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic                m_ack,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                timeout_err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                valid_q, we_q, err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_sel;
   logic [DATA_W/8-1:0] be_q;
   logic                busy, to, done, grant_mem, grant_if;

   assign busy      = state_q != IDLE;
   // Fires in the TIMEOUT-th busy cycle; a real ack in that cycle wins.
   assign to        = busy && !m_ack && (cnt_q == CW'(TIMEOUT - 1));
   assign done      = busy && (m_ack || to);
   assign grant_mem = !busy && mem_req;
   assign grant_if  = !busy && !mem_req && if_req && !if_flush;
   assign rdata_sel = to ? DATA_W'(MEM_ERR_DATA) : m_rdata;

   assign if_ready  = state_q == BUSY_IF && done && !if_flush;
   assign mem_ready = state_q == BUSY_MEM && done;
   assign if_rdata  = if_ready ? rdata_sel : '0;
   assign mem_rdata = mem_ready ? rdata_sel : '0;

   assign m_valid     = valid_q;
   assign m_we        = we_q;
   assign m_addr      = addr_q;
   assign m_wdata     = wdata_q;
   assign m_be        = be_q;
   assign timeout_err = err_q;

   always_comb begin
      state_d = !busy ? (grant_mem ? BUSY_MEM : grant_if ? BUSY_IF : IDLE)
              : done ? IDLE
              : (state_q == BUSY_IF && if_flush) ? DISCARD : state_q;
      cnt_d   = (busy && !done) ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_q | to;
         if (grant_mem || grant_if) begin
            valid_q <= 1'b1;
            we_q    <= grant_mem & mem_we;
            addr_q  <= grant_mem ? mem_addr : if_addr;
            wdata_q <= grant_mem ? mem_wdata : '0;
            be_q    <= grant_mem ? mem_be : '1;
         end else if (done) begin
            valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   logic        clk = 0, reset = 1;
   logic        if_req = 0, if_flush = 0, mem_req = 0, mem_we = 0, m_ack = 0;
   logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, m_rdata = 0;
   logic [3:0]  mem_be = 0;
   logic        if_ready, mem_ready, m_valid, m_we, timeout_err;
   logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
   logic [3:0]  m_be;

   typedef struct {bit is_mem; logic [31:0] data; logic [31:0] addr; bit we;} exp_t;
   exp_t sb[$];
   int total = 0, bad = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ready(if_ready), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit is_mem, input logic [31:0] data, input logic [31:0] addr, input bit we);
      exp_t e;
      e.is_mem = is_mem; e.data = data; e.addr = addr; e.we = we;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (if_ready || mem_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got if=%b mem=%b want none", if_ready, mem_ready);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ready_port", {30'b0, mem_ready, if_ready}, e.is_mem ? 32'd2 : 32'd1);
            check("rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
            check("ack_m_addr", m_addr, e.addr);
            check("ack_m_we", {31'b0, m_we}, {31'b0, e.we});
         end
      end else if (!reset && (if_rdata != 0 || mem_rdata != 0)) begin
         check("idle_rdata", if_rdata | mem_rdata, 32'h0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check("rst_m_valid", {31'b0, m_valid}, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_err", {31'b0, timeout_err}, 0);
      check("rst_ready", {30'b0, if_ready, mem_ready}, 0);
      tick(); tick();
      reset = 0;
      tick();

      // lone fetch, ack 3 cycles after m_valid
      if_req = 1; if_addr = 32'h40;
      for (int i = 0; i < 20 && !m_valid; i++) tick();
      check("lone_valid", {31'b0, m_valid}, 1);
      check("lone_m_be", {28'b0, m_be}, 32'hF);
      tick(); tick(); tick();
      push(0, 32'h2002_0005, 32'h40, 0);
      m_ack = 1; m_rdata = 32'h2002_0005;
      tick();
      m_ack = 0; m_rdata = 0; if_req = 0;
      check("lone_after_valid", {31'b0, m_valid}, 0);
      tick();

      // m_ack while idle is ignored
      m_ack = 1; m_rdata = 32'h1111_1111;
      tick();
      m_ack = 0; m_rdata = 0;
      check("idle_ack_valid", {31'b0, m_valid}, 0);
      tick();

      // simultaneous requests: MEM first
      if_req = 1; if_addr = 32'h80;
      mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'h55; mem_be = 4'b0011;
      tick();
      check("sim_m_valid", {31'b0, m_valid}, 1);
      check("sim_m_we", {31'b0, m_we}, 1);
      check("sim_m_addr", m_addr, 32'h100);
      check("sim_m_wdata", m_wdata, 32'h55);
      check("sim_m_be", {28'b0, m_be}, 32'h3);
      tick();
      push(1, 32'h1234, 32'h100, 1);
      m_ack = 1; m_rdata = 32'h1234;
      tick();
      m_ack = 0; m_rdata = 0; mem_req = 0; mem_we = 0;
      check("sim_gap_valid", {31'b0, m_valid}, 0);
      tick();
      check("sim_if_valid", {31'b0, m_valid}, 1);
      check("sim_if_addr", m_addr, 32'h80);
      check("sim_if_we", {31'b0, m_we}, 0);
      check("sim_if_be", {28'b0, m_be}, 32'hF);
      check("sim_if_wdata", m_wdata, 0);

      // same-cycle ack, next grant two cycles after the first
      push(0, 32'hA5A5_0001, 32'h80, 0);
      m_ack = 1; m_rdata = 32'hA5A5_0001;
      tick();
      m_ack = 0; m_rdata = 0; if_addr = 32'hC0;
      check("same_gap_valid", {31'b0, m_valid}, 0);
      tick();
      check("same_next_valid", {31'b0, m_valid}, 1);
      check("same_next_addr", m_addr, 32'hC0);
      push(0, 32'h0BAD_F00D, 32'hC0, 0);
      m_ack = 1; m_rdata = 32'h0BAD_F00D;
      tick();
      m_ack = 0; m_rdata = 0; if_req = 0;
      tick();

      // flush in flight, ack two cycles later
      if_req = 1; if_addr = 32'h200;
      tick();
      tick();
      if_flush = 1; if_req = 0;
      tick();
      if_flush = 0;
      check("flush_hold_valid", {31'b0, m_valid}, 1);
      tick();
      m_ack = 1; m_rdata = 32'h7777_7777;
      tick();
      m_ack = 0; m_rdata = 0;
      check("flush_idle_valid", {31'b0, m_valid}, 0);
      tick();

      // flush coinciding with ack
      if_req = 1; if_addr = 32'h240;
      tick();
      tick();
      if_flush = 1; if_req = 0; m_ack = 1; m_rdata = 32'h8888_8888;
      tick();
      if_flush = 0; m_ack = 0; m_rdata = 0;
      check("flushack_valid", {31'b0, m_valid}, 0);
      check("flushack_err", {31'b0, timeout_err}, 0);
      tick();

      // timeout: memory never acks
      mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_be = 4'hF;
      tick();
      push(1, 32'hDEAD_BEEF, 32'h300, 0);
      for (int i = 0; i < 7; i++) tick();
      check("to_last_valid", {31'b0, m_valid}, 1);
      check("to_err_before", {31'b0, timeout_err}, 0);
      tick();
      mem_req = 0;
      check("to_valid_clear", {31'b0, m_valid}, 0);
      check("to_err_set", {31'b0, timeout_err}, 1);
      tick(); tick(); tick();
      check("to_err_sticky", {31'b0, timeout_err}, 1);

      // async reset mid BUSY_MEM
      mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'h99;
      tick();
      check("ar_busy_valid", {31'b0, m_valid}, 1);
      #2 reset = 1;
      #1;
      check("ar_valid", {31'b0, m_valid}, 0);
      check("ar_addr", m_addr, 0);
      check("ar_wdata", m_wdata, 0);
      check("ar_err", {31'b0, timeout_err}, 0);
      check("ar_ready", {30'b0, if_ready, mem_ready}, 0);
      mem_req = 0; mem_we = 0;
      tick();
      reset = 0;
      tick();
      if_req = 1; if_addr = 32'h500;
      for (int i = 0; i < 20 && !m_valid; i++) tick();
      check("ar_fetch_valid", {31'b0, m_valid}, 1);
      tick();
      push(0, 32'hCAFE_0042, 32'h500, 0);
      m_ack = 1; m_rdata = 32'hCAFE_0042;
      tick();
      m_ack = 0; m_rdata = 0; if_req = 0;
      tick(); tick();
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
